// File: rtl/mult_err_sweep_ctrl.sv
// mult_err_sweep_ctrl: sweeps every operand pair (a,b) in [0..a_max]x[0..b_max]
// through an external multiplier with LAT cycles of latency. It compares each
// returned product against the exact product and counts compared and
// mismatching pairs.
// Optional feature macro: MULT_ERR_SWEEP_DIST_EN adds the error-distance
// outputs sum_abs_err and max_abs_err.
module mult_err_sweep_ctrl #(
    parameter int WIDTH = 16,
    parameter int LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 hold,
    input  logic [WIDTH-1:0]     a_max,
    input  logic [WIDTH-1:0]     b_max,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   approx_y,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2*WIDTH:0]     total_cnt,
    output logic [2*WIDTH:0]     err_cnt
`ifdef MULT_ERR_SWEEP_DIST_EN
    ,
    output logic [4*WIDTH-1:0]   sum_abs_err,
    output logic [2*WIDTH-1:0]   max_abs_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] IDX_ONE = 1;
    localparam logic [2*WIDTH:0] CNT_ONE = 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_max_q, b_max_q;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               aborted_q, aborted_d;
    logic [2*WIDTH:0]   total_q, total_d;
    logic [2*WIDTH:0]   err_q, err_d;

    logic               issue;      // a pair is presented and counted this cycle
    logic               kill;       // abort honoured this cycle
    logic               last_pair;  // current operands are the final pair
    logic [2*WIDTH-1:0] exact_now;  // exact product of the presented pair
    logic               cmp_vld;    // tag at the comparison point
    logic [2*WIDTH-1:0] cmp_exact;  // exact product travelling with that tag
    logic               pending;    // tags still inside the line (excluding the compare point)
    logic               cnt_en;
    logic               mismatch;

    assign issue     = (state_q == S_RUN) && !hold && !abort;
    assign kill      = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign last_pair = (op_a_q == a_max_q) && (op_b_q == b_max_q);
    assign exact_now = {{WIDTH{1'b0}}, op_a_q} * {{WIDTH{1'b0}}, op_b_q};
    assign cnt_en    = cmp_vld && !kill;
    assign mismatch  = (approx_y != cmp_exact);

    generate
        if (LAT == 0) begin : g_nodly
            assign cmp_vld   = issue;
            assign cmp_exact = exact_now;
            assign pending   = 1'b0;
        end else begin : g_dly
            logic [LAT-1:0]     vld_q;
            logic [2*WIDTH-1:0] prod_q [LAT];

            // Tag and exact-product delay line matching the multiplier latency; abort empties it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        prod_q[i] <= '0;
                    end
                end else begin
                    vld_q[0]  <= issue;
                    prod_q[0] <= exact_now;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i]  <= vld_q[i-1] && !kill;
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end

            // Any valid tag that has not yet reached the compare point
            always_comb begin
                pending = 1'b0;
                for (int i = 0; i < LAT - 1; i++) begin
                    pending = pending | vld_q[i];
                end
            end

            assign cmp_vld   = vld_q[LAT-1];
            assign cmp_exact = prod_q[LAT-1];
        end
    endgenerate

    // Next-state, operand stepping and counter update
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        aborted_d = aborted_q;
        total_d   = total_q;
        err_d     = err_q;

        if (cnt_en) begin
            total_d = total_q + CNT_ONE;
            if (mismatch) begin
                err_d = err_q + CNT_ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    op_a_d    = '0;
                    op_b_d    = '0;
                    aborted_d = 1'b0;
                    total_d   = '0;
                    err_d     = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (issue) begin
                    if (last_pair) begin
                        // Operands stay parked on the final pair; no wrap past the bounds
                        state_d = (LAT == 0) ? S_DONE : S_DRAIN;
                    end else if (op_b_q == b_max_q) begin
                        op_b_d = '0;
                        op_a_d = op_a_q + IDX_ONE;
                    end else begin
                        op_b_d = op_b_q + IDX_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (!pending) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, counter registers and bounds latched at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_max_q   <= '0;
            b_max_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            aborted_q <= 1'b0;
            total_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            aborted_q <= aborted_d;
            total_q   <= total_d;
            err_q     <= err_d;
            if ((state_q == S_IDLE) && start) begin
                a_max_q <= a_max;
                b_max_q <= b_max;
            end
        end
    end

`ifdef MULT_ERR_SWEEP_DIST_EN
    logic [2*WIDTH-1:0] abs_err;
    logic [4*WIDTH-1:0] sum_q, sum_d;
    logic [2*WIDTH-1:0] max_q, max_d;

    assign abs_err = (approx_y >= cmp_exact) ? (approx_y - cmp_exact) : (cmp_exact - approx_y);

    // Error-distance accumulation, updated alongside err_cnt
    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        if ((state_q == S_IDLE) && start) begin
            sum_d = '0;
            max_d = '0;
        end else if (cnt_en && mismatch) begin
            sum_d = sum_q + {{(2*WIDTH){1'b0}}, abs_err};
            if (abs_err > max_q) begin
                max_d = abs_err;
            end
        end
    end

    // Error-distance registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            max_q <= '0;
        end else begin
            sum_q <= sum_d;
            max_q <= max_d;
        end
    end

    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;
`endif

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
    assign total_cnt = total_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_mult_err_sweep_ctrl.sv
// Bench for mult_err_sweep_ctrl (WIDTH=4, LAT=2). A behavioural multiplier stub
// with selectable error modes feeds approx_y. Expected operand pairs are queued
// at start and popped on every issuing cycle. Sweep results are checked against
// a table of hand-derived expectations. When MULT_ERR_SWEEP_DIST_EN is defined,
// the distance outputs are checked as well.
module tb_mult_err_sweep_ctrl;

    localparam int W   = 4;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           hold = 1'b0;
    logic [W-1:0]   a_max = '0;
    logic [W-1:0]   b_max = '0;
    logic [W-1:0]   op_a, op_b;
    logic [2*W-1:0] approx_y;
    logic           busy, done, aborted;
    logic [2*W:0]   total_cnt, err_cnt;
`ifdef MULT_ERR_SWEEP_DIST_EN
    logic [4*W-1:0] sum_abs_err;
    logic [2*W-1:0] max_abs_err;
`endif

    mult_err_sweep_ctrl #(.WIDTH(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .a_max     (a_max),
        .b_max     (b_max),
        .op_a      (op_a),
        .op_b      (op_b),
        .approx_y  (approx_y),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .total_cnt (total_cnt),
        .err_cnt   (err_cnt)
`ifdef MULT_ERR_SWEEP_DIST_EN
        ,
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier stub: remembers the presented operands for LAT cycles
    int             mode = 0;
    logic [W-1:0]   hist_a [LAT];
    logic [W-1:0]   hist_b [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            hist_a[i] <= hist_a[i-1];
            hist_b[i] <= hist_b[i-1];
        end
        hist_a[0] <= op_a;
        hist_b[0] <= op_b;
    end

    function automatic logic [2*W-1:0] stub_y(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
        logic [2*W-1:0] ex;
        ex = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (m)
            1:       return (a == b) ? (ex ^ 8'd1) : ex;
            2:       return ex + {{W{1'b0}}, a};
            3:       return (b != 0) ? (ex - {{W{1'b0}}, a}) : ex;
            default: return ex;
        endcase
    endfunction

    assign approx_y = stub_y(hist_a[LAT-1], hist_b[LAT-1], mode);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int a_mx, b_mx, md;
        int hold_s, hold_n;
        int abort_c;
        int restart;
        int e_total, e_err, e_done, e_ab, e_sum, e_max;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    pair_t sb_q[$];
    vec_t  vecs[13];

    task automatic run_vec(input int idx, input vec_t v);
        pair_t p;
        int    done_c;
        sb_q.delete();
        for (int a = 0; a <= v.a_mx; a++) begin
            for (int b = 0; b <= v.b_mx; b++) begin
                p.a = W'(a);
                p.b = W'(b);
                sb_q.push_back(p);
            end
        end
        @(negedge clk);
        mode  = v.md;
        a_max = W'(v.a_mx);
        b_max = W'(v.b_mx);
        start = 1'b1;
        done_c = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) check($sformatf("v%0d busy_c1", idx), busy, 1);
            if (done) begin
                done_c = c;
                break;
            end
            start = (v.restart != 0) && (c <= 3);
            hold  = (v.hold_n > 0) && (c >= v.hold_s) && (c < v.hold_s + v.hold_n);
            abort = (c == v.abort_c);
            if (!hold && !abort && (v.abort_c == 0 || c < v.abort_c) && sb_q.size() > 0) begin
                p = sb_q.pop_front();
                if (op_a !== p.a || op_b !== p.b)
                    check($sformatf("v%0d pair_c%0d", idx, c), {op_a, op_b}, {p.a, p.b});
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        check($sformatf("v%0d done_cycle", idx), done_c, v.e_done);
        check($sformatf("v%0d total", idx), total_cnt, v.e_total);
        check($sformatf("v%0d err", idx), err_cnt, v.e_err);
        check($sformatf("v%0d aborted", idx), aborted, v.e_ab);
        check($sformatf("v%0d busy_at_done", idx), busy, 0);
        if (v.abort_c == 0) check($sformatf("v%0d pairs_left", idx), sb_q.size(), 0);
`ifdef MULT_ERR_SWEEP_DIST_EN
        check($sformatf("v%0d sum_abs", idx), sum_abs_err, v.e_sum);
        check($sformatf("v%0d max_abs", idx), max_abs_err, v.e_max);
`endif
        $display("[TB] vec %0d a_max=%0d b_max=%0d mode=%0d total=%0d err=%0d done_cyc=%0d aborted=%0d",
                 idx, v.a_mx, v.b_mx, v.md, total_cnt, err_cnt, done_c, aborted);
        @(negedge clk);
        check($sformatf("v%0d done_after", idx), done, 0);
        check($sformatf("v%0d busy_after", idx), busy, 0);
        check($sformatf("v%0d total_held", idx), total_cnt, v.e_total);
    endtask

    initial begin
        //           a  b  md hs hn ab rs  tot err done ab sum max
        vecs[0]  = '{3, 3, 0, 0, 0, 0, 0,  16,  0, 19, 0,  0, 0};
        vecs[1]  = '{3, 3, 1, 0, 0, 0, 0,  16,  4, 19, 0,  4, 1};
        vecs[2]  = '{3, 3, 0, 5, 3, 0, 0,  16,  0, 22, 0,  0, 0};
        vecs[3]  = '{7, 7, 1, 0, 0,10, 0,   7,  1, 11, 1,  1, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,   1,  0,  4, 0,  0, 0};
        vecs[5]  = '{2, 0, 1, 0, 0, 0, 0,   3,  1,  6, 0,  1, 1};
        vecs[6]  = '{0, 5, 1, 0, 0, 0, 0,   6,  1,  9, 0,  1, 1};
        vecs[7]  = '{15,15,1, 0, 0, 0, 0, 256, 16,259, 0, 16, 1};
        vecs[8]  = '{3, 3, 2, 0, 0, 0, 0,  16, 12, 19, 0, 24, 3};
        vecs[9]  = '{3, 3, 3, 0, 0, 0, 0,  16,  9, 19, 0, 18, 3};
        vecs[10] = '{1, 1, 0, 0, 0, 5, 0,   2,  0,  6, 1,  0, 0};
        vecs[11] = '{1, 1, 0, 0, 0, 4, 0,   1,  0,  5, 1,  0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 1,   1,  0,  4, 0,  0, 0};

        // Reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_total", total_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start_busy", busy, 0);

        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i]);
        end

        // Asynchronous reset mid-sweep, then a fresh start is required
        @(negedge clk);
        mode  = 0;
        a_max = 4'd7;
        b_max = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ops", {op_a, op_b}, 0);
        check("arst_total", total_cnt, 0);
        check("arst_err_ab_done", {err_cnt, aborted, done}, 0);
        $display("[TB] async reset mid-sweep: busy=%0d total=%0d op_a=%0d op_b=%0d", busy, total_cnt, op_a, op_b);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_vec(100, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_err_sweep_ctrl.md
MULT_ERR_SWEEP_CTRL -- requirements
Module: mult_err_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: operand width of the multiplier under test.
REQ-002 Parameter LAT, default 0, legal 0..4: pipeline latency of the external multiplier in clock cycles.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin a sweep; sampled in IDLE only.
REQ-006 abort  input  1  terminate a sweep early; sampled in RUN/DRAIN.
REQ-007 hold  input  1  suspend operand issue in RUN.
REQ-008 a_max, b_max  input  WIDTH each  inclusive upper bounds of the sweep; latched at start.
REQ-009 op_a, op_b  output  WIDTH each  registered operands driven to the multiplier.
REQ-010 approx_y  input  2*WIDTH  multiplier product for the operands presented LAT cycles earlier.
REQ-011 busy  output  1  high in RUN and DRAIN.
REQ-012 done  output  1  one-cycle pulse at sweep completion or abort.
REQ-013 aborted  output  1  set with done when ended by abort; cleared on start.
REQ-014 total_cnt, err_cnt  output  2*WIDTH+1 each  compared pairs; mismatching pairs.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE->RUN on start=1: latch a_max/b_max; clear op_a, op_b, counters, aborted.
REQ-017 In RUN with hold=0, one pair SHALL issue per cycle, with b the fastest index: b 0..b_max, then b=0, a+1.
REQ-018 With hold=1, op_a/op_b SHALL stay frozen and no pair SHALL issue; in-flight pairs still complete.
REQ-019 An issue-valid tag plus the exact product op_a*op_b SHALL travel through a LAT-deep delay line; when LAT=0 there is no delay.
REQ-020 When a delayed tag is valid, total_cnt SHALL increment, and err_cnt SHALL increment if approx_y != the delayed exact product.
REQ-021 After issuing (a_max,b_max), RUN->DRAIN; DRAIN->DONE once the delay line holds no valid tag.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 Latency: with hold=0 and N=(a_max+1)*(b_max+1), counting the cycle after the start edge as cycle 1, done SHALL be high in cycle N+LAT+1 with final counts visible.
REQ-024 a_max=b_max=0 SHALL issue exactly one pair.
REQ-025 Full range: N=2^(2*WIDTH) SHALL fit in total_cnt without wrap.
REQ-026 Index counters SHALL compare against the latched bounds; they SHALL never wrap past them.
REQ-027 Abort in RUN/DRAIN SHALL stop issue at once and discard in-flight tags; next cycle is DONE with aborted=1; counts hold their values at abort.
REQ-028 If abort and the last issue coincide, abort SHALL take priority.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 Counters and aborted SHALL hold their values in IDLE until the next start.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and clear all outputs, counters, the delay line and the latched bounds to 0, including mid-sweep.
REQ-032 The first sweep after reset release SHALL need a fresh start.

Configuration
REQ-033 With macro MULT_ERR_SWEEP_DIST_EN defined, the block SHALL add these outputs:
- sum_abs_err, 4*WIDTH wide: accumulated |approx_y - exact|.
- max_abs_err, 2*WIDTH wide: largest |approx_y - exact| seen.
Both update with err_cnt and clear on start and reset.
REQ-034 Without MULT_ERR_SWEEP_DIST_EN, these ports and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-035 LAT=0, exact stub, a_max=b_max=3, start -> total_cnt=16, err_cnt=0, done in cycle 17, aborted=0.
REQ-036 LAT=2, stub returns exact^1 when a==b, a_max=b_max=3 -> err_cnt=4, done in cycle 19; with DIST_EN, sum_abs_err=4 and max_abs_err=1.
REQ-037 LAT=1, a_max=b_max=3, hold=1 for cycles 5..7 -> op sequence is stalled with no skipped or duplicated pairs, total_cnt=16, done in cycle 21.
REQ-038 LAT=2, a_max=b_max=7, abort in cycle 10 -> done with aborted=1 in cycle 11, total_cnt=7, busy=0 afterwards.
REQ-039 rst_n pulsed low mid-sweep -> all outputs are 0 asynchronously; a start after release gives a correct full sweep.
REQ-040 a_max=b_max=0 with start re-asserted during RUN -> exactly one pair compared, and the second start is ignored.
